// File: rtl/evm_ballot_ctrl.sv
// Ballot-unit controller: one vote per issued ballot, per-candidate saturating
// counters (last index is NOTA) and a registered indexed readout port.
module evm_ballot_ctrl #(
    parameter int NUM_CAND    = 9,
    parameter int CNT_W       = 8,
    parameter int SEL_W       = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ballot_issue,
    input  logic             vote_valid,
    input  logic [SEL_W-1:0] vote_sel,
    input  logic             close_poll,
    output logic             ready,
    output logic             vote_ack,
    output logic             invalid_sel,
    output logic             timeout,
    output logic             poll_closed,
    output logic             sat_flag,
    output logic [CNT_W-1:0] total_votes,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_count
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W:0]   NC       = (SEL_W+1)'(NUM_CAND);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        CLOSED = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt [NUM_CAND];
    logic [CNT_W-1:0] rd_mux;
    logic             sel_ok;
    logic             rec, inv, tmo, tmr_clr, tmr_inc;

    assign sel_ok      = ({1'b0, vote_sel} < NC);
    assign ready       = (state == ARMED);
    assign poll_closed = (state == CLOSED);

    // Priority: close_poll > vote > timeout > ballot_issue; a valid vote still
    // counts when it lands together with close_poll.
    always_comb begin
        state_nxt = state;
        rec       = 1'b0;
        inv       = 1'b0;
        tmo       = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (close_poll) begin
                    state_nxt = CLOSED;
                end else if (ballot_issue) begin
                    state_nxt = ARMED;
                    tmr_clr   = 1'b1;
                end
            end
            ARMED: begin
                if (vote_valid && sel_ok) begin
                    rec       = 1'b1;
                    state_nxt = close_poll ? CLOSED : IDLE;
                end else if (close_poll) begin
                    state_nxt = CLOSED;
                end else if (vote_valid) begin
                    inv     = 1'b1;
                    tmr_clr = 1'b1;
                end else if (tmr == TMR_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            CLOSED:  state_nxt = CLOSED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if ({1'b0, rd_idx} == (SEL_W+1)'(i)) rd_mux = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmr         <= '0;
            vote_ack    <= 1'b0;
            invalid_sel <= 1'b0;
            timeout     <= 1'b0;
            sat_flag    <= 1'b0;
            total_votes <= '0;
            rd_count    <= '0;
            for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
        end else begin
            state       <= state_nxt;
            vote_ack    <= rec;
            invalid_sel <= inv;
            timeout     <= tmo;
            rd_count    <= rd_mux;
            if (tmr_clr)      tmr <= '0;
            else if (tmr_inc) tmr <= tmr + 1'b1;
            if (rec) begin
                if (total_votes == CNT_MAX) sat_flag    <= 1'b1;
                else                        total_votes <= total_votes + 1'b1;
                for (int i = 0; i < NUM_CAND; i++) begin
                    if ({1'b0, vote_sel} == (SEL_W+1)'(i)) begin
                        if (cnt[i] == CNT_MAX) sat_flag <= 1'b1;
                        else                   cnt[i]   <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/evm_ballot_ctrl.md
Name: evm_ballot_ctrl

Overview:
Parametrised successor to the fixed nine-party EVM counter. It holds NUM_CAND per-candidate vote counters, with the last index reserved for NOTA. A ballot-unit FSM enforces exactly one vote per issued ballot, with a timeout, invalid-selection rejection and saturating counts. Once the poll is closed, results are read out through an indexed, registered read port. The block sits between the presiding-officer control panel and the result display or readout logic.

Parameters:
NUM_CAND, 9, number of candidates including NOTA (index NUM_CAND-1); legal range 2..64
CNT_W, 8, width of each vote counter and of total_votes
SEL_W, 4, width of vote_sel and rd_idx; must satisfy 2**SEL_W >= NUM_CAND
TIMEOUT_CYC, 1000, number of ARMED cycles without a vote before the ballot is voided; legal range 2..2**20

Ports:
clk  in  1  system clock; all logic rising-edge
rst  in  1  synchronous active-high reset
ballot_issue  in  1  officer pulse that arms one ballot
vote_valid  in  1  voter pressed a candidate button
vote_sel  in  SEL_W  candidate index, sampled when vote_valid=1
close_poll  in  1  officer pulse that ends polling (sticky)
ready  out  1  high in ARMED: a vote is accepted this cycle
vote_ack  out  1  one-cycle pulse: a vote was recorded
invalid_sel  out  1  one-cycle pulse: vote_sel >= NUM_CAND rejected
timeout  out  1  one-cycle pulse: ballot voided by timeout
poll_closed  out  1  high in CLOSED
sat_flag  out  1  sticky: some counter saturated and dropped a vote
total_votes  out  CNT_W  number of recorded votes (saturating)
rd_idx  in  SEL_W  readout candidate index
rd_count  out  CNT_W  registered count of candidate rd_idx

Behaviour:
- Reset values:
  - FSM returns to IDLE.
  - All counters, total_votes, rd_count, sat_flag and the timeout counter are 0.
  - All pulse outputs, ready and poll_closed are 0.
  - A reset in any state, including mid-ballot or CLOSED, clears everything in the same edge.
- States: IDLE, ARMED, CLOSED. Priority within a cycle: rst > close_poll > vote > timeout > ballot_issue.
- IDLE:
  - ballot_issue=1 -> ARMED; the timeout counter loads 0.
  - close_poll=1 -> CLOSED.
  - vote_valid is ignored; no flag is raised.
- ARMED (ready=1):
  - Valid vote (vote_valid=1 and vote_sel < NUM_CAND) -> cnt[vote_sel] and total_votes increment at that edge. vote_ack pulses on the following cycle; state -> IDLE.
  - Invalid vote (vote_valid=1 and vote_sel >= NUM_CAND) -> no count change. invalid_sel pulses on the following cycle; state stays ARMED and the timeout counter restarts at 0.
  - Timeout: the counter increments every ARMED cycle with no valid vote. On reaching TIMEOUT_CYC-1 the next edge -> IDLE, timeout pulses, and no count changes.
  - ballot_issue while ARMED is ignored: no re-arm, and the timer is not reset.
  - close_poll together with a valid vote: the vote is counted and vote_ack pulses, then the state -> CLOSED.
  - close_poll without a vote -> CLOSED; the ballot is voided without a timeout pulse.
- CLOSED:
  - Terminal until rst. poll_closed=1 and ready=0.
  - ballot_issue, vote_valid and close_poll are all ignored.
- Saturation:
  - A counter at 2**CNT_W-1 holds its value. sat_flag sets and vote_ack still pulses.
  - total_votes saturates independently and also sets sat_flag.
- Readout:
  - rd_count <= (rd_idx < NUM_CAND) ? cnt[rd_idx] : 0, registered with 1-cycle latency.
  - Readout works in every state, so live counts are visible.
  - rd_count reflects a count updated at edge N from edge N+1 onward.
- vote_ack, invalid_sel and timeout are mutually exclusive and each lasts exactly 1 cycle.

Test Plan:
1. Reset, then for each of the ballot sequence sel=0,1,0,1,0,0,7,0,5,0,8: ballot_issue, then vote_valid. Expected: cnt0=6, cnt1=2, cnt5=1, cnt7=1, cnt8=1, total_votes=11, 11 vote_ack pulses, all other counts 0.
2. Issue a ballot, vote sel=12 (NUM_CAND=9), then sel=3. Expected: invalid_sel pulses once, cnt3=1, total_votes=1, and the FSM stays ARMED between the two votes.
3. TIMEOUT_CYC=10: issue a ballot, no vote for 10 cycles. Expected: timeout pulses once on cycle 10, state IDLE, ready=0. A later vote_valid changes nothing.
4. CNT_W=3: record 9 votes for sel=2. Expected: cnt2=7, sat_flag=1, total_votes=7, 9 vote_ack pulses.
5. In ARMED, assert close_poll and vote_valid(sel=4) in the same cycle. Expected: cnt4 increments, vote_ack pulses, poll_closed=1. A following ballot_issue and vote are ignored; rd_idx=4 gives rd_count=1 one cycle later.
6. Assert rst mid-ARMED after 3 votes. Expected: all counts 0, state IDLE, poll_closed=0, and rd_count=0 on the next cycle.
